// File: rtl/adc_proc_multi.sv
`default_nettype none
// ============================================================================
// adc_proc_multi
//   Per-channel ADC sample averaging, millivolt scaling and one-entry output
//   holding register. Optional result clamp enabled by ADC_PROC_CLAMP_EN.
//   Revision: 1.0
// ============================================================================
module adc_proc_multi #(
  parameter int DATA_W   = 16,
  parameter int CH_N     = 4,
  parameter int AVG_LOG2 = 2,
  parameter int FS_MV    = 1600,
  parameter int CLAMP_MV = 1500,
  localparam int CH_W    = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [CH_W-1:0]   adc_ch,
  input  logic              valid_in,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] result_data,
  output logic [CH_W-1:0]   result_ch,
  output logic              ovf,
  output logic              clamp_flag
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  // With AVG_LOG2=0 the counter is pinned at zero, so every sample is "last".
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CH_N);
  localparam logic [DATA_W-1:0] FS_K     = DATA_W'(FS_MV);
`ifdef ADC_PROC_CLAMP_EN
  localparam logic [DATA_W-1:0] CLAMP_K  = DATA_W'(CLAMP_MV);
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Stage 1: per-channel accumulation
  logic [ACC_W-1:0]  acc_q [CH_N];
  logic [ACC_W-1:0]  acc_d [CH_N];
  logic [CNT_W-1:0]  cnt_q [CH_N];
  logic [CNT_W-1:0]  cnt_d [CH_N];
  logic              ch_ok;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] mean_q, mean_d;
  logic [CH_W-1:0]   mean_ch_q, mean_ch_d;
  logic              mean_vld_q, mean_vld_d;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mean_d     = mean_q;
    mean_ch_d  = mean_ch_q;
    mean_vld_d = 1'b0;
    ch_ok      = ({1'b0, adc_ch} < CH_LIMIT);
    sum        = acc_q[adc_ch] + ACC_W'(adc_data);
    if (valid_in && ch_ok) begin
      if (cnt_q[adc_ch] == CNT_LAST) begin
        acc_d[adc_ch] = '0;
        cnt_d[adc_ch] = '0;
        mean_d        = sum[ACC_W-1:AVG_LOG2];
        mean_ch_d     = adc_ch;
        mean_vld_d    = 1'b1;
      end else begin
        acc_d[adc_ch] = sum;
        cnt_d[adc_ch] = cnt_q[adc_ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_N; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      mean_q     <= '0;
      mean_ch_q  <= '0;
      mean_vld_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mean_q     <= mean_d;
      mean_ch_q  <= mean_ch_d;
      mean_vld_q <= mean_vld_d;
    end
  end

  // Stage 2: scale to millivolts, truncating the full-precision product
  logic [DATA_W-1:0] scaled;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [CH_W-1:0]   s2_ch_q, s2_ch_d;
  logic              s2_vld_q, s2_vld_d;

  always_comb begin
    scaled    = DATA_W'(({{DATA_W{1'b0}}, mean_q} * {{DATA_W{1'b0}}, FS_K}) >> DATA_W);
    s2_data_d = scaled;
`ifdef ADC_PROC_CLAMP_EN
    if (scaled > CLAMP_K) begin
      s2_data_d = CLAMP_K;
    end
`endif
    s2_ch_d   = mean_ch_q;
    s2_vld_d  = mean_vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_data_q <= '0;
      s2_ch_q   <= '0;
      s2_vld_q  <= 1'b0;
    end else begin
      s2_data_q <= s2_data_d;
      s2_ch_q   <= s2_ch_d;
      s2_vld_q  <= s2_vld_d;
    end
  end

  // Output holding register
  state_t            state_q, state_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic              ovf_q, ovf_d;
  logic              wr_fire;
  logic              load;

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
    ovf_d      = ovf_q;
    wr_fire    = (state_q == PEND) && !fifo_full;
    // A slot being emptied this cycle may be refilled without loss.
    load       = s2_vld_q && ((state_q == IDLE) || wr_fire);
    if (wr_fire) begin
      state_d = IDLE;
    end
    if (load) begin
      state_d    = PEND;
      res_data_d = s2_data_q;
      res_ch_d   = s2_ch_q;
    end else if (s2_vld_q) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      res_data_q <= '0;
      res_ch_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_en       = wr_fire;
  assign result_data = res_data_q;
  assign result_ch   = res_ch_q;
  assign ovf         = ovf_q;

`ifdef ADC_PROC_CLAMP_EN
  logic s2_clamp_q, s2_clamp_d;
  logic res_clamp_q, res_clamp_d;

  always_comb begin
    s2_clamp_d  = (scaled > CLAMP_K);
    res_clamp_d = res_clamp_q;
    if (load) begin
      res_clamp_d = s2_clamp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_clamp_q  <= 1'b0;
      res_clamp_q <= 1'b0;
    end else begin
      s2_clamp_q  <= s2_clamp_d;
      res_clamp_q <= res_clamp_d;
    end
  end

  assign clamp_flag = res_clamp_q;
`else
  logic unused_clamp_mv;
  assign unused_clamp_mv = ^CLAMP_MV;
  assign clamp_flag      = 1'b0;
`endif

endmodule
`default_nettype wire
